cordic_vector_mc: RTL and testbench

- Multi-channel iterative CORDIC vectoring engine, the successor to the single-channel phase/radius FSM in the phase-measurement path.
- Accepts (I, Q) sample pairs from NUM_CH independent channels over per-channel valid/ready handshakes and arbitrates between them round-robin.
- Computes phase atan2(Q, I) and scaled radius for one channel at a time.
- Emits results with a channel tag on a single valid/ready output stream with backpressure. The angle table is generated internally at elaboration.

---
 rtl/cordic_vector_mc.sv | 177 +++++++++++++++++
 tb/tb_cordic_vector_mc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector_mc.sv
// rtl/cordic_vector_mc.sv - multi-channel round-robin iterative CORDIC vectoring engine
//
// Takes (I, Q) pairs from NUM_CH channels. It grants one channel at a time in
// round-robin order and produces atan2(Q, I) plus the CORDIC-scaled radius,
// tagged with the source channel, on one output stream that supports backpressure.
//
// Ports:
//   clk_i        clock
//   reset_ni     asynchronous active-low reset
//   in_valid_i   per-channel sample valid
//   in_ready_o   per-channel accept, one-hot or zero, only while idle
//   i_i, q_i     per-channel signed I / Q samples (IN_W each)
//   out_valid_o  result valid, held until out_ready_i
//   out_ready_i  downstream accept
//   out_ch_o     channel tag of the result
//   phi_o        signed phase, PI code == +pi, clamped to [-PI, PI]
//   r_o          radius (about 1.64676 x magnitude), never negative
//   busy_o       engine not idle
module cordic_vector_mc #(
   parameter int NUM_CH     = 4,
   parameter int IN_W       = 24,
   parameter int PHI_W      = 26,
   parameter int ITERATIONS = 24,
   parameter int PI         = 8388607,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic [NUM_CH-1:0]           in_valid_i,
   output logic [NUM_CH-1:0]           in_ready_o,
   input  logic [NUM_CH-1:0][IN_W-1:0] i_i,
   input  logic [NUM_CH-1:0][IN_W-1:0] q_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [CH_W-1:0]             out_ch_o,
   output logic signed [PHI_W-1:0]     phi_o,
   output logic signed [IN_W+1:0]      r_o,
   output logic                        busy_o
);
   localparam int  XW   = IN_W + 2;
   localparam int  AW   = PHI_W + 1;
   localparam int  IW   = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
   localparam real PI_R = 3.14159265358979323846;
   localparam logic signed [AW-1:0] PI_POS = AW'(PI);
   localparam logic signed [AW-1:0] PI_NEG = -AW'(PI);

   // round(atan(2^-k) / pi * PI); only ever called with constant k
   function automatic int atan_code(input int k);
      real p;
      real v;
      p = 1.0;
      for (int j = 0; j < k; j++) p = p / 2.0;
      v = $atan(p) / PI_R * real'(PI);
      return $rtoi(v + 0.5);
   endfunction

   logic signed [PHI_W-1:0] atan_tab [ITERATIONS];
   for (genvar k = 0; k < ITERATIONS; k++) begin : g_atan
      assign atan_tab[k] = PHI_W'(atan_code(k));
   end

   typedef enum logic [1:0] {IDLE, PREROT, ITERATE, OUT} state_t;
   state_t state, state_nx;

   logic signed [XW-1:0]    x, y, x_nx, y_nx;
   logic signed [AW-1:0]    phi, phi_nx, atan_ext;
   logic signed [PHI_W-1:0] phi_cl, phi_q;
   logic signed [XW-1:0]    r_q;
   logic [IW-1:0]           it;
   logic                    zero, last_it, gnt_vld;
   logic [CH_W-1:0]         ptr, grant, cand, ch;

   // Search from ptr upward with wrap. The loop walks the offsets downward, so
   // the closest valid channel is written last and wins.
   always_comb begin
      grant   = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         cand = CH_W'((int'(ptr) + k) % NUM_CH);
         if (in_valid_i[cand]) begin
            grant   = cand;
            gnt_vld = 1'b1;
         end
      end
   end

   // One micro-rotation. Both updates read the pre-update x and y.
   always_comb begin
      atan_ext = AW'(atan_tab[it]);
      if (!y[XW-1]) begin
         x_nx   = x + (y >>> it);
         y_nx   = y - (x >>> it);
         phi_nx = phi + atan_ext;
      end else begin
         x_nx   = x - (y >>> it);
         y_nx   = y + (x >>> it);
         phi_nx = phi - atan_ext;
      end
      phi_cl = phi_nx[PHI_W-1:0];
      if (phi_nx > PI_POS)      phi_cl = PI_POS[PHI_W-1:0];
      else if (phi_nx < PI_NEG) phi_cl = PI_NEG[PHI_W-1:0];
   end

   assign last_it = (it == IW'(ITERATIONS - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (gnt_vld) state_nx = PREROT;
         PREROT:  state_nx = ITERATE;
         ITERATE: if (last_it) state_nx = OUT;
         OUT:     if (out_ready_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state <= IDLE;
      else           state <= state_nx;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         x     <= '0;
         y     <= '0;
         phi   <= '0;
         it    <= '0;
         zero  <= 1'b0;
         ptr   <= '0;
         ch    <= '0;
         phi_q <= '0;
         r_q   <= '0;
      end else begin
         case (state)
            IDLE: if (gnt_vld) begin
               x    <= {{2{i_i[grant][IN_W-1]}}, i_i[grant]};
               y    <= {{2{q_i[grant][IN_W-1]}}, q_i[grant]};
               phi  <= '0;
               zero <= 1'b0;
               ch   <= grant;
               ptr  <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
            PREROT: begin
               // Fold the left half-plane into the right half-plane. The half-turn
               // takes its sign from y before negation.
               if (x[XW-1]) begin
                  x   <= -x;
                  y   <= -y;
                  phi <= y[XW-1] ? PI_NEG : PI_POS;
               end
               zero <= (x == '0) && (y == '0);
               it   <= '0;
            end
            ITERATE: begin
               x   <= x_nx;
               y   <= y_nx;
               phi <= phi_nx;
               it  <= it + 1'b1;
               if (last_it) begin
                  phi_q <= zero ? '0 : phi_cl;
                  r_q   <= zero ? '0 : x_nx;
               end
            end
            default: ;
         endcase
      end
   end

   // Gated by reset_ni so that no channel sees ready while reset is asserted.
   assign in_ready_o  = ((state == IDLE) && gnt_vld && reset_ni) ? (NUM_CH'(1) << grant) : '0;
   assign out_valid_o = (state == OUT);
   assign busy_o      = (state != IDLE);
   assign out_ch_o    = ch;
   assign phi_o       = phi_q;
   assign r_o         = r_q;
endmodule

// File: tb/tb_cordic_vector_mc.sv
// tb/tb_cordic_vector_mc.sv - directed table-driven bench for cordic_vector_mc
module tb_cordic_vector_mc;
   localparam int NUM_CH     = 4;
   localparam int IN_W       = 24;
   localparam int PHI_W      = 26;
   localparam int ITERATIONS = 24;
   localparam int PI         = 8388607;
   localparam int CH_W       = 2;
   localparam int TOL        = ITERATIONS;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic [NUM_CH-1:0]           in_valid = '0;
   logic [NUM_CH-1:0]           in_ready;
   logic [NUM_CH-1:0][IN_W-1:0] i_in = '0;
   logic [NUM_CH-1:0][IN_W-1:0] q_in = '0;
   logic                        out_valid;
   logic                        out_ready = 1'b0;
   logic [CH_W-1:0]             out_ch;
   logic signed [PHI_W-1:0]     phi;
   logic signed [IN_W+1:0]      r;
   logic                        busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [CH_W-1:0] ch;
      int i;
      int q;
      int phi;
      int r;
      int tol;
   } vec_t;

   vec_t vecs [8];

   cordic_vector_mc #(
      .NUM_CH(NUM_CH), .IN_W(IN_W), .PHI_W(PHI_W), .ITERATIONS(ITERATIONS), .PI(PI)
   ) dut (
      .clk_i(clk), .reset_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .i_i(i_in), .q_i(q_in), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_ch_o(out_ch), .phi_o(phi), .r_o(r), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp, input int tol);
      total++;
      if (act < exp - tol || act > exp + tol) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Present one sample, wait for the grant, and check latency and result.
   // out_ready is expected high, so the result drains on its own.
   task automatic run_vec(input vec_t v, input string tag);
      logic [NUM_CH-1:0] want;
      int cnt;
      int p;
      int rv;
      bit got;
      want = '0;
      want[v.ch] = 1'b1;
      in_valid = want;
      i_in[v.ch] = IN_W'(v.i);
      q_in[v.ch] = IN_W'(v.q);
      #1;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
         if (in_ready == want) got = 1'b1;
         else @(negedge clk);
      end
      chk({tag, " grant"}, int'(got), 1, 0);
      if (!got) begin
         in_valid = '0;
         return;
      end
      @(negedge clk);
      in_valid = '0;
      cnt = 1;
      while (!out_valid && cnt < 60) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, " latency"}, cnt, ITERATIONS + 2, 0);
      p  = phi;
      rv = r;
      chk({tag, " phi"}, p, v.phi, v.tol);
      chk({tag, " r"}, rv, v.r, v.tol);
      chk({tag, " ch"}, int'(out_ch), int'(v.ch), 0);
      chk({tag, " phi range"}, int'(p >= -PI && p <= PI), 1, 0);
      @(negedge clk);
      chk({tag, " idle after pop"}, int'(busy), 0, 0);
   endtask

   initial begin
      int n;
      int last_acc;
      int gaps_bad;
      int sp;
      int sr;
      bit pulse_ok;
      bit onehot_ok;
      bit stable_ok;
      bit done;
      logic [NUM_CH-1:0] prev_rdy;
      int seq [$];

      //            ch    I          Q          phi        r         tol
      vecs[0] = '{2'd0,  1000000,        0,          0,  1646760, TOL};
      vecs[1] = '{2'd1,        0,  1000000,    4194304,  1646760, TOL};
      vecs[2] = '{2'd2, -1000000,       -1,   -8388604,  1646760, TOL};
      vecs[3] = '{2'd3, -1000000,        0,    8388607,  1646760, TOL};
      vecs[4] = '{2'd0,        0,        0,          0,        0,   0};
      vecs[5] = '{2'd1, -8388608, -8388608,   -6291455, 19535983, TOL};
      vecs[6] = '{2'd2,  3000000,  3000000,    2097152,  6986612, TOL};
      vecs[7] = '{2'd3,  -500000,   800000,    5685862,  1553550, TOL};

      // reset state
      repeat (3) @(negedge clk);
      chk("reset out_valid", int'(out_valid), 0, 0);
      chk("reset busy", int'(busy), 0, 0);
      chk("reset in_ready", int'(in_ready), 0, 0);
      chk("reset phi", int'(phi), 0, 0);
      chk("reset r", int'(r), 0, 0);
      chk("reset out_ch", int'(out_ch), 0, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 8; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // all channels valid and held: fair rotation at the minimum issue interval
      do_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         i_in[c] = IN_W'(100000 * (c + 1));
         q_in[c] = IN_W'(-50000 * c);
      end
      in_valid = '1;
      out_ready = 1'b1;
      #1;
      prev_rdy = '0;
      pulse_ok = 1'b1;
      onehot_ok = 1'b1;
      last_acc = -1;
      gaps_bad = 0;
      for (int t = 0; t < 200 && seq.size() < 5; t++) begin
         if ($countones(in_ready) > 1) onehot_ok = 1'b0;
         if ((in_ready & prev_rdy) != '0) pulse_ok = 1'b0;
         if (in_ready != '0) begin
            if (last_acc >= 0 && t - last_acc != ITERATIONS + 3) gaps_bad++;
            last_acc = t;
         end
         if (out_valid) seq.push_back(int'(out_ch));
         prev_rdy = in_ready;
         @(negedge clk);
      end
      chk("rr count", seq.size(), 5, 0);
      for (int k = 0; k < seq.size(); k++) chk($sformatf("rr order %0d", k), seq[k], k % NUM_CH, 0);
      chk("rr ready one-hot", int'(onehot_ok), 1, 0);
      chk("rr ready single pulse", int'(pulse_ok), 1, 0);
      chk("rr issue interval", gaps_bad, 0, 0);
      in_valid = '0;
      done = 1'b0;
      for (int t = 0; t < 60 && !done; t++) begin
         if (!busy) done = 1'b1;
         else @(negedge clk);
      end
      chk("rr drain", int'(done), 1, 0);

      // backpressure while OUT
      do_reset();
      out_ready = 1'b0;
      in_valid = 4'b0010;
      i_in[1] = IN_W'(0);
      q_in[1] = IN_W'(1000000);
      #1;
      chk("bp grant ch1", int'(in_ready), 2, 0);
      @(negedge clk);
      in_valid = 4'b1000;
      i_in[3] = IN_W'(1000000);
      q_in[3] = IN_W'(0);
      n = 0;
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("bp out_valid", int'(out_valid), 1, 0);
      sp = phi;
      sr = r;
      chk("bp phi", sp, 4194304, TOL);
      chk("bp r", sr, 1646760, TOL);
      stable_ok = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (!out_valid || int'(phi) != sp || int'(r) != sr || out_ch != 2'd1 || in_ready != '0)
            stable_ok = 1'b0;
      end
      chk("bp stable", int'(stable_ok), 1, 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp idle after release", int'(busy), 0, 0);
      chk("bp next grant ch3", int'(in_ready), 8, 0);
      @(negedge clk);
      in_valid = '0;
      n = 0;
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("bp ch3 tag", int'(out_ch), 3, 0);
      chk("bp ch3 phi", int'(phi), 0, TOL);
      @(negedge clk);

      // asynchronous reset in the middle of ITERATE
      in_valid = 4'b0010;
      i_in[1] = IN_W'(0);
      q_in[1] = IN_W'(1000000);
      #1;
      chk("ar grant ch1", int'(in_ready), 2, 0);
      @(negedge clk);
      in_valid = '0;
      repeat (8) @(negedge clk);
      chk("ar busy mid-iterate", int'(busy), 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar out_valid", int'(out_valid), 0, 0);
      chk("ar busy", int'(busy), 0, 0);
      chk("ar phi", int'(phi), 0, 0);
      chk("ar r", int'(r), 0, 0);
      chk("ar out_ch", int'(out_ch), 0, 0);
      @(negedge clk);
      in_valid = 4'b0100;
      #1;
      chk("ar in_ready held low", int'(in_ready), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      vecs[7].ch = 2'd2;
      run_vec(vecs[7], "after reset ch2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
